// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_RSV2  = 2'd2,
        ST_RSV3  = 2'd3
    } pipe_state_t;

    // Zero register: a load targeting it never creates a real dependency
    localparam logic [4:0] XZR_IDX = 5'd31;

    localparam int WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use dependency comparator
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       MemRead_ex,
    input  logic [4:0] Rd_ex,
    input  logic [4:0] Rn_id,
    input  logic [4:0] Rm_id,
    input  logic       uses_Rm_id,
    output logic       load_use
);

    // A load in EX feeds a source register of the instruction in ID
    always_comb begin
        load_use = MemRead_ex && (Rd_ex != XZR_IDX) &&
                   ((Rd_ex == Rn_id) || (uses_Rm_id && (Rd_ex == Rm_id)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller; HAZ_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_ex,
    input  logic [4:0]  Rd_ex,
    input  logic [4:0]  Rn_id,
    input  logic [4:0]  Rm_id,
    input  logic        uses_Rm_id,
    input  logic        BrTaken_mem,
    input  logic        dm_req_mem,
    input  logic        dm_ready,
    output logic        pc_en,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic [1:0]  state,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        mem_timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    pipe_state_t   state_q;
    pipe_state_t   state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_nxt;
    logic          timeout_set;
    logic          freeze_all;
    logic          use_eval;
    logic          load_use;

    hazard_detect u_hazard_detect (
        .MemRead_ex (MemRead_ex),
        .Rd_ex      (Rd_ex),
        .Rn_id      (Rn_id),
        .Rm_id      (Rm_id),
        .uses_Rm_id (uses_Rm_id),
        .load_use   (load_use)
    );

    assign state = state_q;

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Sticky timeout flag, only cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_timeout <= 1'b0;
        end else if (timeout_set) begin
            mem_timeout <= 1'b1;
        end
    end

    // Next-state decode: memory freeze, wait bookkeeping and timeout release
    always_comb begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        freeze_all   = 1'b0;
        use_eval     = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (dm_req_mem && !dm_ready) begin
                    freeze_all   = 1'b1;
                    use_eval     = 1'b0;
                    state_nxt    = ST_MWAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_MWAIT: begin
                if (dm_ready) begin
                    state_nxt = ST_RUN;
                end else if (wait_cnt == CNT_LAST) begin
                    // Give up on the access: record it and let the pipe move
                    timeout_set = 1'b1;
                    use_eval    = 1'b0;
                    state_nxt   = ST_RUN;
                end else begin
                    freeze_all   = 1'b1;
                    use_eval     = 1'b0;
                    state_nxt    = ST_MWAIT;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output decode: freeze beats branch flush, branch flush beats load-use stall
    always_comb begin
        pc_en        = 1'b1;
        en_if_id     = 1'b1;
        en_id_ex     = 1'b1;
        en_ex_mem    = 1'b1;
        en_mem_wb    = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (freeze_all) begin
            pc_en     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (use_eval) begin
            if (BrTaken_mem) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                en_if_id    = 1'b0;
                flush_id_ex = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_if_id && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int WM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_ex;
    logic [4:0]  Rd_ex;
    logic [4:0]  Rn_id;
    logic [4:0]  Rm_id;
    logic        uses_Rm_id;
    logic        BrTaken_mem;
    logic        dm_req_mem;
    logic        dm_ready;
    logic        pc_en;
    logic        en_if_id;
    logic        en_id_ex;
    logic        en_ex_mem;
    logic        en_mem_wb;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_ex_mem;
    logic [1:0]  state;
    logic        mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_MAX(WM)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead_ex   (MemRead_ex),
        .Rd_ex        (Rd_ex),
        .Rn_id        (Rn_id),
        .Rm_id        (Rm_id),
        .uses_Rm_id   (uses_Rm_id),
        .BrTaken_mem  (BrTaken_mem),
        .dm_req_mem   (dm_req_mem),
        .dm_ready     (dm_ready),
        .pc_en        (pc_en),
        .en_if_id     (en_if_id),
        .en_id_ex     (en_id_ex),
        .en_ex_mem    (en_ex_mem),
        .en_mem_wb    (en_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .state        (state),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .mem_timeout  (mem_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_q[$];

    // Reference model: "are we waiting on memory", how long, and has it ever timed out
    bit     m_waiting;
    int     m_waited;
    bit     m_timeout;
    longint m_stall;
    longint m_flush;

    function automatic logic [10:0] observed();
        return {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                flush_if_id, flush_id_ex, flush_ex_mem, state, mem_timeout};
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic model_clear();
        m_waiting = 0;
        m_waited  = 0;
        m_timeout = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    // Drive one cycle of inputs, push the expected outputs, advance past the edge
    task automatic cycle(input bit mr, input int rd, input int rn, input int rm,
                         input bit urm, input bit br, input bit req, input bit rdy);
        bit       hz;
        bit       evaluate;
        bit [4:0] en;
        bit [2:0] fl;
        bit       nxt_waiting;
        int       nxt_waited;
        bit       nxt_timeout;
        MemRead_ex  = mr;
        Rd_ex       = 5'(rd);
        Rn_id       = 5'(rn);
        Rm_id       = 5'(rm);
        uses_Rm_id  = urm;
        BrTaken_mem = br;
        dm_req_mem  = req;
        dm_ready    = rdy;
        hz = mr && (rd != 31) && ((rd == rn) || (urm && (rd == rm)));
        en = 5'b11111;
        fl = 3'b000;
        evaluate    = 1;
        nxt_waiting = m_waiting;
        nxt_waited  = m_waited;
        nxt_timeout = m_timeout;
        if (!m_waiting) begin
            if (req && !rdy) begin
                en = 5'b00000;
                evaluate = 0;
                nxt_waiting = 1;
                nxt_waited = 0;
            end
        end else if (rdy) begin
            nxt_waiting = 0;
        end else if (m_waited == WM - 1) begin
            evaluate = 0;
            nxt_timeout = 1;
            nxt_waiting = 0;
        end else begin
            en = 5'b00000;
            evaluate = 0;
            nxt_waited = m_waited + 1;
        end
        if (evaluate) begin
            if (br) begin
                fl = 3'b111;
            end else if (hz) begin
                en[4] = 1'b0;
                en[3] = 1'b0;
                fl[1] = 1'b1;
            end
        end
        exp_q.push_back({en, fl, (m_waiting ? 2'd1 : 2'd0), m_timeout});
        if (reset) begin
            m_waiting = nxt_waiting;
            m_waited  = nxt_waited;
            m_timeout = nxt_timeout;
            if (!en[4]) m_stall++;
            if (fl[2]) m_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 7));
    endfunction

    // Monitor: compare every cycle the stimulus has an expectation for
    always @(negedge clk) begin
        logic [10:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got %b expected %b", $time, observed(), e);
            end
        end
    end

    initial begin
        int thr;
        reset = 1'b0;
        MemRead_ex = 0; Rd_ex = 0; Rn_id = 0; Rm_id = 0; uses_Rm_id = 0;
        BrTaken_mem = 0; dm_req_mem = 0; dm_ready = 0;
        model_clear();
        @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_timeout", mem_timeout, 0);
        // RUN decode while held in reset, including a memory stall request
        cycle(1, 5, 5, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 1);
        reset = 1'b1;

        // Load-use on Rn, zero register, unused Rm
        cycle(1, 5, 5, 0, 0, 0, 0, 1);
        cycle(0, 5, 5, 0, 0, 0, 0, 1);
        cycle(1, 31, 31, 0, 0, 0, 0, 1);
        cycle(1, 5, 0, 5, 0, 0, 0, 1);
        cycle(1, 5, 0, 5, 1, 0, 0, 1);

        // Memory wait three cycles then ready
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // Branch beats load-use; freeze beats branch
        cycle(1, 5, 5, 0, 0, 1, 0, 1);
        cycle(1, 5, 5, 0, 0, 1, 1, 0);
        cycle(1, 5, 5, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // Timeout: memory never answers
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
        chk("timeout_set", mem_timeout, 1);
        chk("timeout_state", state, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk("timeout_sticky", mem_timeout, 1);

        // Asynchronous reset in the middle of a wait
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mwait_entered", state, 1);
        reset = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_timeout", mem_timeout, 0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
`ifdef HAZ_PERF_CNT_EN
        for (int i = 0; i < 5; i++) cycle(1, 3, 3, 0, 0, 0, 0, 1);
        chk("stall_cnt_5", stall_cnt, 5);
`endif

        // Randomized traffic with varying memory responsiveness
        for (int blk = 0; blk < 15; blk++) begin
            thr = int'($urandom_range(1, 7));
            for (int i = 0; i < 100; i++) begin
                cycle(bit'($urandom_range(0, 1)), rnd_reg(), rnd_reg(), rnd_reg(),
                      bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) < thr));
            end
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cnt_total", stall_cnt, m_stall);
        chk("flush_cnt_total", flush_cnt, m_flush);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
